// File: rtl/mips150_lsu.sv
// mips150_lsu: single-outstanding load/store unit with lane steering, alignment check and wait timeout.
module mips150_lsu #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic                op_store,
   input  logic [1:0]          op_size,
   input  logic                op_unsigned,
   input  logic [ADDR_W-1:0]   op_addr,
   input  logic [DATA_W-1:0]   op_wdata,
   input  logic [4:0]          op_rd,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                res_valid,
   output logic [DATA_W-1:0]   res_data,
   output logic [4:0]          res_rd,
   output logic                res_regwrite,
   output logic                res_misalign,
   output logic                res_timeout
);
   localparam int NB = DATA_W / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = $clog2(TIMEOUT + 1) + 1;
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic store_q, uns_q, mis, tmo;
   logic [1:0] size_q;
   logic [OW-1:0] off, off_q;
   logic [7:0] bm;
   logic [2:0] am;
   logic [6:0] k;
   logic [NB-1:0] be;
   logic [DATA_W-1:0] wsh, wd, rs, t, ld;
   assign off = op_addr[OW-1:0];
   assign op_ready = state == IDLE;
   assign tmo = cnt >= CW'(TIMEOUT - 1);
   always_comb begin
      bm = 8'((9'd1 << (4'd1 << op_size)) - 9'd1);
      am = (3'd1 << op_size) - 3'd1;
      mis = |(op_addr[2:0] & am) | (op_size == 2'd3 && DATA_W == 32);
      be = NB'(bm) << off;
      wsh = op_wdata << {off, 3'b000};
      wd = wsh;
      for (int i = 0; i < NB; i++)
         if (!be[i]) wd[8*i +: 8] = 8'h00;
      // Park the loaded field at the top, then shift back down to extend it.
      rs = mem_rdata >> {off_q, 3'b000};
      k = 7'(DATA_W) - (7'd8 << size_q);
      t = rs << k;
      if (uns_q) ld = t >> k;
      else ld = $signed(t) >>> k;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         store_q <= 1'b0;
         uns_q <= 1'b0;
         size_q <= 2'd0;
         off_q <= '0;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_be <= '0;
         mem_wdata <= '0;
         res_valid <= 1'b0;
         res_data <= '0;
         res_rd <= 5'd0;
         res_regwrite <= 1'b0;
         res_misalign <= 1'b0;
         res_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: if (op_valid) begin
               store_q <= op_store;
               size_q <= op_size;
               uns_q <= op_unsigned;
               off_q <= off;
               cnt <= '0;
               res_rd <= op_rd;
               res_data <= '0;
               res_misalign <= mis;
               res_timeout <= 1'b0;
               res_regwrite <= 1'b0;
               res_valid <= mis;
               mem_req <= !mis;
               mem_we <= op_store;
               mem_addr <= op_addr & ~ADDR_W'(NB - 1);
               mem_be <= be;
               mem_wdata <= op_store ? wd : '0;
               state <= mis ? DONE : REQ;
            end
            REQ: if (mem_gnt) begin
               mem_req <= 1'b0;
               cnt <= cnt + 1'b1;
               res_valid <= store_q;
               state <= store_q ? DONE : RESP;
            end else if (tmo) begin
               mem_req <= 1'b0;
               res_timeout <= 1'b1;
               res_valid <= 1'b1;
               state <= DONE;
            end else cnt <= cnt + 1'b1;
            RESP: if (mem_rvalid) begin
               res_data <= ld;
               res_regwrite <= 1'b1;
               res_valid <= 1'b1;
               state <= DONE;
            end else if (tmo) begin
               res_timeout <= 1'b1;
               res_valid <= 1'b1;
               state <= DONE;
            end else cnt <= cnt + 1'b1;
            DONE: begin
               res_valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/mips150_lsu.md
MIPS150_LSU -- requirements
Module: mips150_lsu

Interface
REQ-001 Parameter DATA_W, default 32, memory/register data width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles spent waiting on memory before error; SHALL be at least 1.
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 Ports op_valid (input, 1) and op_ready (output, 1): operation handshake.
REQ-007 Port op_store, input, 1: 1 = store, 0 = load.
REQ-008 Port op_size, input, 2: 00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
REQ-009 Port op_unsigned, input, 1: loads zero-extend when 1 and sign-extend when 0.
REQ-010 Ports op_addr (input, ADDR_W), op_wdata (input, DATA_W) and op_rd (input, 5): byte address, store data in the low bits, and destination register tag.
REQ-011 Ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_be (output, DATA_W/8) and mem_wdata (output, DATA_W): memory request.
REQ-012 Ports mem_gnt (input, 1), mem_rvalid (input, 1) and mem_rdata (input, DATA_W): memory grant and read return.
REQ-013 Ports res_valid (output, 1), res_data (output, DATA_W), res_rd (output, 5), res_regwrite (output, 1), res_misalign (output, 1) and res_timeout (output, 1): completion.

Function
REQ-014 FSM states SHALL be IDLE, REQ, RESP and DONE; op_ready SHALL be 1 only in IDLE.
REQ-015 On op_valid and op_ready in the same cycle, the block SHALL latch all op_* fields. The transfer is one outstanding operation; no new operation is accepted until after DONE.
REQ-016 Misalignment rules:
- Misaligned = address not a multiple of the access size, or op_size=11 with DATA_W=32.
- A misaligned op SHALL go IDLE->DONE with res_misalign=1 and res_regwrite=0.
- A misaligned op SHALL NOT assert mem_req.
REQ-017 Aligned op SHALL go IDLE->REQ.
REQ-018 In REQ, mem_req SHALL be 1, and mem_we, mem_addr, mem_be and mem_wdata SHALL be stable until mem_gnt=1.
REQ-019 mem_addr SHALL be op_addr with its low log2(DATA_W/8) bits cleared.
REQ-020 Byte-enable and store-data lane rules:
- mem_be SHALL have size-many consecutive ones starting at lane op_addr mod (DATA_W/8).
- Store data SHALL be the low-order op_wdata bytes shifted to the same lanes.
- Lanes not enabled SHALL be 0.
REQ-021 For loads, mem_be SHALL equal the load lanes and mem_we SHALL be 0.
REQ-022 REQ with mem_gnt: a store SHALL go to DONE and a load SHALL go to RESP.
REQ-023 In RESP, on mem_rvalid=1:
- The block SHALL extract the addressed lanes from mem_rdata.
- It SHALL extend them to DATA_W according to op_unsigned and register the result into res_data.
- It SHALL then go to DONE.
REQ-024 mem_rvalid outside RESP SHALL be ignored.
REQ-025 A wait counter SHALL clear on entry to REQ and increment each cycle in REQ or RESP. When it reaches TIMEOUT without the awaited event, the block SHALL go to DONE with res_timeout=1, res_regwrite=0 and mem_req deasserted.
REQ-026 DONE SHALL last exactly one cycle with res_valid=1, then return to IDLE; res_* SHALL be valid only while res_valid=1.
REQ-027 res_regwrite SHALL be 1 for successful loads and 0 for stores and all errors; res_rd SHALL equal the latched op_rd.
REQ-028 Minimum latency: an aligned load with gnt in its first REQ cycle and rvalid one cycle later SHALL assert res_valid 3 cycles after acceptance. An aligned store with immediate gnt SHALL assert res_valid 2 cycles after acceptance.
REQ-029 When mem_gnt and the timeout limit occur in the same cycle, the grant SHALL win; likewise mem_rvalid SHALL win over timeout in RESP.

Reset
REQ-030 While rst_n=0:
- The FSM SHALL be IDLE and the counter 0.
- op_ready SHALL be 1 once rst_n is deasserted.
- All other outputs SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL abort it immediately, with no res_valid and mem_req dropped asynchronously.

Verification
REQ-032 LB op_addr=0x1003, op_unsigned=0, DATA_W=32, mem_rdata=0x80FFFFFF -> mem_addr=0x1000, mem_be=1000b, res_data=0xFFFFFF80, res_regwrite=1.
REQ-033 SH op_addr=0x2002, op_wdata=0x0000BEEF -> mem_be=1100b, mem_wdata=0xBEEF0000, mem_we=1, res_regwrite=0.
REQ-034 LW op_addr=0x0006 -> no mem_req, res_misalign=1, res_valid exactly one cycle after acceptance.
REQ-035 LHU op_addr=0x0002 with mem_gnt held 0, TIMEOUT=4 -> res_timeout=1 after 4 REQ cycles, mem_req then 0.
REQ-036 rst_n pulsed low while in RESP -> res_valid never asserted, op_ready=1 after release; a following LW completes normally.
REQ-037 DATA_W=64, LD op_addr=0x10, op_size=11 -> mem_be=0xFF, res_data=mem_rdata; the same op with DATA_W=32 -> res_misalign=1.
